// File: rtl/cam_ctrl_if.sv
// Request/response handshake bundle between the tag-management logic and cam_ctrl.
// master = requester side, slave = cam_ctrl side.
interface cam_ctrl_if #(
  parameter int DATA_WIDTH = 5,
  parameter int DATA_SIZE  = 1 << DATA_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_SIZE-1:0]  req_key;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic [DATA_WIDTH-1:0] rsp_index;
  logic [DATA_SIZE-1:0]  rsp_data;
  logic                  rsp_evict;

  modport master (
    output req_valid, req_op, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_index, rsp_data, rsp_evict
  );

  modport slave (
    input  req_valid, req_op, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_index, rsp_data, rsp_evict
  );
endinterface

// File: rtl/cam_ctrl.sv
// Lookup/insert front end for the cam block: one request at a time, round-robin allocation on insert miss.
// Define CAM_CTRL_READ_EN to enable op 10 (CAM entry read); otherwise READ answers like the reserved op.
module cam_ctrl #(
  parameter int DATA_WIDTH = 5,
  parameter int DATA_SIZE  = 1 << DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cam_ctrl_if.slave             bus,
  output logic                  full_o,
  output logic [DATA_WIDTH:0]   count_o,
  output logic                  search_enable_o,
  output logic [DATA_SIZE-1:0]  search_data_o,
  output logic                  write_enable_o,
  output logic [DATA_WIDTH-1:0] write_index_o,
  output logic [DATA_SIZE-1:0]  write_data_o,
  output logic                  read_enable_o,
  output logic [DATA_WIDTH-1:0] read_index_o,
  input  logic [DATA_WIDTH-1:0] cam_search_index_i,
  input  logic                  cam_search_valid_i,
  input  logic [DATA_SIZE-1:0]  cam_read_value_i,
  input  logic                  cam_read_valid_i
);

`ifdef CAM_CTRL_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [DATA_WIDTH:0] FULL_CNT = (DATA_WIDTH+1)'(DATA_SIZE);

  typedef enum logic [2:0] {IDLE, SEARCH, WAIT, WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_SIZE-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] alloc_q, alloc_d;
  logic [DATA_WIDTH:0]   count_q, count_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [DATA_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic [DATA_SIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_evict_q, rsp_evict_d;
  logic                  srch_en_q, srch_en_d;
  logic [DATA_SIZE-1:0]  srch_data_q, srch_data_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [DATA_SIZE-1:0]  wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] rd_idx_q, rd_idx_d;

  function automatic logic is_search(input logic [1:0] op);
    return (op == OP_LOOKUP) || (op == OP_INSERT);
  endfunction

  // Without the read feature READ falls through the "unsupported" path and never touches the CAM.
  function automatic logic is_read(input logic [1:0] op);
    return READ_EN && (op == OP_READ);
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    alloc_d     = alloc_q;
    count_d     = count_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    rsp_evict_d = rsp_evict_q;
    srch_en_d   = 1'b0;
    srch_data_d = srch_data_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_idx_d    = rd_idx_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d        = bus.req_op;
        key_d       = bus.req_key;
        rsp_hit_d   = 1'b0;
        rsp_index_d = '0;
        rsp_data_d  = '0;
        rsp_evict_d = 1'b0;
        state_d     = SEARCH;
        // CAM strobes are registered so they are high for exactly the SEARCH cycle.
        if (is_search(bus.req_op)) begin
          srch_en_d   = 1'b1;
          srch_data_d = bus.req_key;
        end else if (is_read(bus.req_op)) begin
          rd_en_d  = 1'b1;
          rd_idx_d = bus.req_key[DATA_WIDTH-1:0];
        end
      end
      SEARCH: state_d = (is_search(op_q) || is_read(op_q)) ? WAIT : RESP;
      WAIT: begin
        if (is_read(op_q)) begin
          rsp_hit_d   = cam_read_valid_i;
          rsp_data_d  = cam_read_value_i;
          rsp_index_d = key_q[DATA_WIDTH-1:0];
          state_d     = RESP;
        end else if (cam_search_valid_i || op_q == OP_LOOKUP) begin
          rsp_hit_d   = cam_search_valid_i;
          rsp_index_d = cam_search_index_i;
          state_d     = RESP;
        end else begin
          wr_en_d   = 1'b1;
          wr_idx_d  = alloc_q;
          wr_data_d = key_q;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        rsp_hit_d   = 1'b0;
        rsp_index_d = alloc_q;
        rsp_evict_d = (count_q == FULL_CNT);
        alloc_d     = alloc_q + 1'b1;
        if (count_q != FULL_CNT) count_d = count_q + 1'b1;
        state_d     = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= '0;
      key_q       <= '0;
      alloc_q     <= '0;
      count_q     <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
      rsp_evict_q <= 1'b0;
      srch_en_q   <= 1'b0;
      srch_data_q <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      alloc_q     <= alloc_d;
      count_q     <= count_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      rsp_evict_q <= rsp_evict_d;
      srch_en_q   <= srch_en_d;
      srch_data_q <= srch_data_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_hit   = bus.rsp_valid & rsp_hit_q;
  assign bus.rsp_index = bus.rsp_valid ? rsp_index_q : '0;
  assign bus.rsp_data  = bus.rsp_valid ? rsp_data_q : '0;
  assign bus.rsp_evict = bus.rsp_valid & rsp_evict_q;

  assign full_o          = (count_q == FULL_CNT);
  assign count_o         = count_q;
  assign search_enable_o = srch_en_q;
  assign search_data_o   = srch_data_q;
  assign write_enable_o  = wr_en_q;
  assign write_index_o   = wr_idx_q;
  assign write_data_o    = wr_data_q;
  assign read_enable_o   = rd_en_q;
  assign read_index_o    = rd_idx_q;

endmodule
